cnt_share_arb: RTL and testbench
================================

Name: cnt_share_arb

Overview:
- Round-robin scheduler that shares one W-bit up-counter (interval timer) among NREQ requesters.
- Each requester asks for an interval of len+1 clock cycles.
- The block grants one requester at a time, runs the shared counter from 0 to the requested length, then pulses that requester's done.
- Sits between timed-event clients and the counter datapath; the counter is internal and its value is exported on y.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 8, counter and length width in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- res  input  1  synchronous reset, active-high; sampled on rising edge of clk only.
- req  input  NREQ  per-requester request level; must stay high until done or the request is aborted.
- len  input  NREQ*W  per-requester interval length, requester i in bits [i*W+W-1 : i*W]; sampled only at grant.
- gnt  output  NREQ  one-hot grant, registered.
- done  output  NREQ  one-cycle completion pulse to the granted requester, registered.
- busy  output  1  high whenever state is not IDLE.
- y  output  W  current shared counter value, registered.

Behaviour:
- Clock and reset: one clock (clk); reset (res) synchronous, active-high. With res high at a rising edge:
  - state=IDLE, gnt=0, done=0, y=0, busy=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
  - Reset overrides everything, including mid-RUN. No done is issued for an interrupted grant.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req is nonzero, select the first set req bit scanning ptr, ptr+1, …, wrapping mod NREQ.
  - At that edge: gnt=onehot(sel), len of sel latched into tgt, y=0, state=RUN.
  - If req is 0, hold.
- RUN:
  - Each edge, y=y+1, unless y==tgt.
  - If y==tgt at an edge: state=DONE, gnt=0, done[sel]=1, y=0, ptr=(sel+1) mod NREQ.
  - Result: gnt is high for exactly tgt+1 cycles. tgt=0 gives a one-cycle grant.
- Abort: if req[sel] is low at an edge in RUN, it takes precedence over completion:
  - state=IDLE, gnt=0, y=0, no done, ptr=(sel+1) mod NREQ.
- DONE:
  - One cycle only; done clears at the next edge and state=IDLE.
  - No grant is issued from DONE, so the minimum gap between grants is one IDLE cycle.
- Requester handshake:
  - Requester i drops req[i] in the cycle it sees done[i].
  - If req stays high, requester i re-arbitrates in IDLE at lowest priority, since ptr has moved past it.
- Arithmetic:
  - y never wraps: it stops at tgt ≤ 2^W−1.
  - tgt=2^W−1 is legal: y reaches all-ones, then clears to 0 on DONE.
- Other boundary rules:
  - len changes during RUN are ignored.
  - Simultaneous requests are resolved purely by ptr order.
  - req bits of non-granted requesters may toggle freely.
- busy=1 in RUN and DONE.
- Invariants: at most one gnt bit and at most one done bit high; done and gnt are never high together.

Test Plan:
1. Reset then single request: res high 2 cycles, then req=0010, len1=3.
   - gnt=0010 for 4 cycles; y steps 0,1,2,3.
   - done=0010 pulses once, the cycle after y=3.
   - busy drops the cycle after done; ptr=2.
2. Round-robin fairness: req=1111 held, all len=1.
   - Grants occur in order 0,1,2,3,0.
   - Each grant lasts 2 cycles and is followed by a 1-cycle done; grants are 4 cycles apart.
3. Zero and maximum length: len0=0 gives a 1-cycle grant with y=0 then done.
   - len0=255 (W=8) gives a 256-cycle grant; y reaches 255 then clears to 0, with no wrap to 0 mid-grant.
4. Abort: grant requester 2 with len=10, drop req[2] when y=4.
   - Next edge: gnt=0, y=0, state IDLE, no done pulse.
   - Pending req[3] is granted the following edge.
5. Reset mid-operation: grant requester 1 with len=20, assert res at y=7.
   - Next edge: gnt=0, done=0, y=0, busy=0.
   - After release with req=1111, requester 0 is granted first.
6. Len stability: change len of the granted requester from 5 to 2 during RUN.
   - Grant still lasts 6 cycles and y reaches 5.

Source files
------------

// File: rtl/cnt_share_arb.sv
// ---------------------------------------------------------------------------
// cnt_share_arb
//
// Round-robin scheduler that shares one W-bit interval counter among NREQ
// requesters. A granted requester i holds the counter for len[i]+1 cycles,
// after which it receives a one-cycle done pulse. The pointer then moves past
// the requester that was just served, so a requester that keeps its request
// up drops to lowest priority.
//
// Ports:
//   clk   - system clock, all logic on the rising edge
//   res   - synchronous active-high reset
//   req   - per-requester request level (held until done or abort)
//   len   - per-requester interval length, requester i in [i*W +: W],
//           sampled only when the grant is issued
//   gnt   - registered one-hot grant
//   done  - registered one-cycle completion pulse to the served requester
//   busy  - high while the scheduler is not in IDLE
//   y     - registered value of the shared counter
// ---------------------------------------------------------------------------
module cnt_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                res,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   len,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic                busy,
    output logic [W-1:0]        y
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q,   ptr_d;
    logic [PW-1:0]     sel_q,   sel_d;
    logic [W-1:0]      tgt_q,   tgt_d;
    logic [W-1:0]      y_q,     y_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic [NREQ-1:0]   done_q,  done_d;

    logic              arbHit;
    logic [PW-1:0]     arbSel;
    logic [W-1:0]      selLen;

    // Pointer advance with wrap at NREQ, which need not be a power of two.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] s);
        if (s == PW'(NREQ - 1)) begin
            nextPtr = '0;
        end else begin
            nextPtr = s + 1'b1;
        end
    endfunction

    // Round-robin search starting at ptr_q. The loop runs from the farthest
    // offset down to offset 0 so the candidate nearest the pointer is the
    // last one written and therefore wins.
    always_comb begin
        arbHit = 1'b0;
        arbSel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            logic [PW-1:0] cand;
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (req[cand]) begin
                arbHit = 1'b1;
                arbSel = cand;
            end
        end
    end

    // Length of the winning requester, latched into tgt at grant time only.
    assign selLen = len[arbSel*W +: W];

    // Next-state logic. In RUN, an abort (granted request dropped) is checked
    // before completion so a requester that leaves on the last cycle gets no
    // done. Both exits move the pointer past the served requester.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        y_d     = y_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (arbHit) begin
                    state_d        = RUN;
                    sel_d          = arbSel;
                    tgt_d          = selLen;
                    y_d            = '0;
                    gnt_d          = '0;
                    gnt_d[arbSel]  = 1'b1;
                end
            end
            RUN: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    y_d     = '0;
                    ptr_d   = nextPtr(sel_q);
                end else if (y_q == tgt_q) begin
                    state_d       = DONE;
                    gnt_d         = '0;
                    done_d[sel_q] = 1'b1;
                    y_d           = '0;
                    ptr_d         = nextPtr(sel_q);
                end else begin
                    y_d = y_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                y_d     = '0;
            end
        endcase
    end

    // State and registered outputs. Reset wins over any in-flight grant and
    // never produces a done for it.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            tgt_q   <= '0;
            y_q     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            y_q     <= y_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign y    = y_q;
    assign busy = (state_q != IDLE);

    // Structural invariants of the grant/done outputs.
    gntOneHot : assert property (@(posedge clk) disable iff (res) $onehot0(gnt_q));
    doneOneHot : assert property (@(posedge clk) disable iff (res) $onehot0(done_q));
    gntDoneExcl : assert property (@(posedge clk) disable iff (res) (gnt_q & done_q) == '0);

endmodule

// File: tb/tb_cnt_share_arb.sv
// ---------------------------------------------------------------------------
// tb_cnt_share_arb
//
// Directed bench for cnt_share_arb (NREQ=4, W=8). Inputs are driven 1ns
// after the rising edge and outputs are checked at that same point, so every
// observed value is the one registered on the preceding edge.
// ---------------------------------------------------------------------------
module tb_cnt_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic                clk;
    logic                res;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   len;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic                busy;
    logic [W-1:0]        y;

    int total;
    int bad;

    cnt_share_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk  (clk),
        .res  (res),
        .req  (req),
        .len  (len),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .y    (y)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive request levels and packed lengths (requester 0 in the low byte).
    task automatic applyStimulus(input logic [NREQ-1:0] r,
                                 input logic [W-1:0] l0, input logic [W-1:0] l1,
                                 input logic [W-1:0] l2, input logic [W-1:0] l3);
        req = r;
        len = {l3, l2, l1, l0};
    endtask

    task automatic doReset();
        res = 1'b1;
        req = '0;
        step();
        step();
        res = 1'b0;
    endtask

    // Main directed sequence.
    initial begin
        total = 0;
        bad   = 0;
        res   = 1'b1;
        req   = '0;
        len   = '0;

        // Test 1: reset, then a single request from requester 1 with len=3.
        doReset();
        checkOutput("rst_gnt",  32'(gnt),  32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_y",    32'(y),    32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        applyStimulus(4'b0010, 8'd0, 8'd3, 8'd0, 8'd0);
        step();
        checkOutput("t1_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_gnt", 32'(gnt), 32'h2);
            checkOutput("t1_y",   32'(y),   32'(i));
            if (i < 3) step();
        end
        step();
        checkOutput("t1_done",     32'(done), 32'h2);
        checkOutput("t1_gnt_off",  32'(gnt),  32'h0);
        checkOutput("t1_y_clr",    32'(y),    32'h0);
        checkOutput("t1_busy_dn",  32'(busy), 32'h1);
        req = '0;
        step();
        checkOutput("t1_done_clr", 32'(done), 32'h0);
        checkOutput("t1_idle",     32'(busy), 32'h0);
        // Pointer should now sit at 2: requester 2 wins an all-ones request.
        applyStimulus(4'b1111, 8'd0, 8'd0, 8'd0, 8'd0);
        step();
        checkOutput("t1_ptr2", 32'(gnt), 32'h4);

        // Test 2: round-robin with all four requesting, len=1 each.
        doReset();
        applyStimulus(4'b1111, 8'd1, 8'd1, 8'd1, 8'd1);
        for (int g = 0; g < 5; g++) begin
            step();
            checkOutput("t2_gnt0", 32'(gnt), 32'(1 << (g % 4)));
            checkOutput("t2_y0",   32'(y),   32'h0);
            step();
            checkOutput("t2_gnt1", 32'(gnt), 32'(1 << (g % 4)));
            checkOutput("t2_y1",   32'(y),   32'h1);
            step();
            checkOutput("t2_done", 32'(done), 32'(1 << (g % 4)));
            checkOutput("t2_gap",  32'(gnt),  32'h0);
            step();
            checkOutput("t2_idle", 32'(busy), 32'h0);
        end

        // Test 3a: zero length gives a one-cycle grant.
        doReset();
        applyStimulus(4'b0001, 8'd0, 8'd0, 8'd0, 8'd0);
        step();
        checkOutput("t3_z_gnt", 32'(gnt), 32'h1);
        checkOutput("t3_z_y",   32'(y),   32'h0);
        step();
        checkOutput("t3_z_done", 32'(done), 32'h1);
        checkOutput("t3_z_gnt0", 32'(gnt),  32'h0);
        req = '0;
        step();
        checkOutput("t3_z_idle", 32'(busy), 32'h0);

        // Test 3b: maximum length gives a 256-cycle grant with no wrap.
        applyStimulus(4'b0001, 8'd255, 8'd0, 8'd0, 8'd0);
        step();
        checkOutput("t3_m_gnt", 32'(gnt), 32'h1);
        checkOutput("t3_m_y0",  32'(y),   32'h0);
        for (int i = 1; i < 256; i++) begin
            step();
            checkOutput("t3_m_walk_y",   32'(y),   32'(i));
            checkOutput("t3_m_walk_gnt", 32'(gnt), 32'h1);
        end
        step();
        checkOutput("t3_m_done", 32'(done), 32'h1);
        checkOutput("t3_m_yclr", 32'(y),    32'h0);
        req = '0;
        step();

        // Test 4: abort requester 2 at y=4 while requester 3 waits.
        doReset();
        applyStimulus(4'b1100, 8'd0, 8'd0, 8'd10, 8'd0);
        step();
        checkOutput("t4_gnt", 32'(gnt), 32'h4);
        for (int i = 0; i < 4; i++) step();
        checkOutput("t4_y4", 32'(y), 32'h4);
        req = 4'b1000;
        step();
        checkOutput("t4_ab_gnt",  32'(gnt),  32'h0);
        checkOutput("t4_ab_y",    32'(y),    32'h0);
        checkOutput("t4_ab_done", 32'(done), 32'h0);
        checkOutput("t4_ab_busy", 32'(busy), 32'h0);
        step();
        checkOutput("t4_next_gnt", 32'(gnt), 32'h8);

        // Test 5: reset in the middle of requester 1's grant.
        doReset();
        applyStimulus(4'b0010, 8'd0, 8'd20, 8'd0, 8'd0);
        step();
        checkOutput("t5_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 7; i++) step();
        checkOutput("t5_y7", 32'(y), 32'h7);
        res = 1'b1;
        step();
        checkOutput("t5_r_gnt",  32'(gnt),  32'h0);
        checkOutput("t5_r_done", 32'(done), 32'h0);
        checkOutput("t5_r_y",    32'(y),    32'h0);
        checkOutput("t5_r_busy", 32'(busy), 32'h0);
        res = 1'b0;
        applyStimulus(4'b1111, 8'd0, 8'd0, 8'd0, 8'd0);
        step();
        checkOutput("t5_first", 32'(gnt), 32'h1);

        // Test 6: length change during RUN is ignored.
        doReset();
        applyStimulus(4'b0001, 8'd5, 8'd0, 8'd0, 8'd0);
        step();
        checkOutput("t6_gnt0", 32'(gnt), 32'h1);
        len[7:0] = 8'd2;
        for (int i = 1; i < 6; i++) begin
            step();
            checkOutput("t6_gnt", 32'(gnt), 32'h1);
            checkOutput("t6_y",   32'(y),   32'(i));
        end
        step();
        checkOutput("t6_done", 32'(done), 32'h1);
        req = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
